// File: rtl/gbt_init_pkg.sv
// ============================================================================
//  Module      : gbt_init_pkg
//  Description : State encoding, timer width and output-decode helpers for the
//                GBT link bring-up sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gbt_init_pkg;

    localparam int TMO_W = 16;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_QPLL_WAIT  = 3'd1;
    localparam logic [2:0] ST_GT_PULSE   = 3'd2;
    localparam logic [2:0] ST_GT_WAIT    = 3'd3;
    localparam logic [2:0] ST_GBT_PULSE  = 3'd4;
    localparam logic [2:0] ST_ALIGN_WAIT = 3'd5;
    localparam logic [2:0] ST_LINK_OK    = 3'd6;
    localparam logic [2:0] ST_FAULT      = 3'd7;

    typedef enum logic [2:0] {
        IDLE       = ST_IDLE,
        QPLL_WAIT  = ST_QPLL_WAIT,
        GT_PULSE   = ST_GT_PULSE,
        GT_WAIT    = ST_GT_WAIT,
        GBT_PULSE  = ST_GBT_PULSE,
        ALIGN_WAIT = ST_ALIGN_WAIT,
        LINK_OK    = ST_LINK_OK,
        FAULT_ST   = ST_FAULT
    } state_t;

    function automatic logic gt_rst_on(state_t s);
        return (s inside {IDLE, QPLL_WAIT, GT_PULSE, FAULT_ST});
    endfunction

    function automatic logic gbt_rst_on(state_t s);
        return !(s inside {ALIGN_WAIT, LINK_OK});
    endfunction

endpackage

`default_nettype wire

// File: rtl/init_tmo_cntr.sv
// ============================================================================
//  Module      : init_tmo_cntr
//  Description : Loadable saturating up-counter with synchronous clear and a
//                terminal-count compare output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module init_tmo_cntr #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    input  logic [W-1:0] i_tc_val,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    // Saturation keeps long-lived states (IDLE, LINK_OK) from wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = (r_count == i_tc_val);

endmodule

`default_nettype wire

// File: rtl/gbt_link_init_seq.sv
// ============================================================================
//  Module      : gbt_link_init_seq
//  Description : GBT optical link bring-up and supervision sequencer with
//                bounded retry. Optional lock-loss statistics counter built
//                when GBT_LINK_STATS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gbt_link_init_seq
    import gbt_init_pkg::*;
#(
    parameter logic [7:0]  RST_PULSE = 8'd16,
    parameter logic [15:0] LOCK_TMO  = 16'd40000,
    parameter logic [15:0] ALIGN_TMO = 16'd40000,
    parameter logic [3:0]  MAX_RETRY = 4'd7,
    parameter logic [3:0]  LOSS_FILT = 4'd8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RUN,
    input  logic       QPLL_LOCK,
    input  logic       GT_RST_DONE,
    input  logic       GBT_RX_READY,
    output logic       GT_RST,
    output logic       GBT_RST,
    output logic       LINK_UP,
    output logic       FAULT,
    output logic [3:0] RETRY_CNT,
    output logic [2:0] STATE,
    output logic [7:0] LOSS_CNT
);

    state_t           r_state;
    state_t           w_nxt;
    logic             r_gt_rst;
    logic             r_gbt_rst;
    logic             r_link_up;
    logic             r_fault;
    logic [3:0]       r_retry_cnt;
    logic             w_retry;
    logic             w_tmr_clr;
    logic             w_tmr_tc;
    logic [TMO_W-1:0] w_tmr_lim;
    logic             w_bad;
    logic             w_flt_clr;
    logic             w_flt_tc;
    logic             w_loss;

    assign w_bad  = !QPLL_LOCK || !GBT_RX_READY;
    assign w_loss = (r_state == LINK_OK) && w_bad && w_flt_tc;

    always_comb begin
        w_tmr_lim = {TMO_W{1'b1}};
        case (r_state)
            QPLL_WAIT, GT_WAIT:   w_tmr_lim = LOCK_TMO - 16'd1;
            GT_PULSE, GBT_PULSE:  w_tmr_lim = {8'd0, RST_PULSE} - 16'd1;
            ALIGN_WAIT:           w_tmr_lim = ALIGN_TMO - 16'd1;
            default:              w_tmr_lim = {TMO_W{1'b1}};
        endcase
    end

    // Success is tested before timeout so a simultaneous pair resolves to success.
    always_comb begin
        w_nxt   = r_state;
        w_retry = 1'b0;
        if (!RUN) begin
            w_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:       w_nxt = QPLL_WAIT;
                QPLL_WAIT:  if (QPLL_LOCK) w_nxt = GT_PULSE;
                            else if (w_tmr_tc) w_retry = 1'b1;
                GT_PULSE:   if (w_tmr_tc) w_nxt = GT_WAIT;
                GT_WAIT:    if (GT_RST_DONE) w_nxt = GBT_PULSE;
                            else if (w_tmr_tc) w_retry = 1'b1;
                GBT_PULSE:  if (w_tmr_tc) w_nxt = ALIGN_WAIT;
                ALIGN_WAIT: if (GBT_RX_READY) w_nxt = LINK_OK;
                            else if (w_tmr_tc) w_retry = 1'b1;
                LINK_OK:    if (w_loss) w_retry = 1'b1;
                FAULT_ST:   w_nxt = FAULT_ST;
                default:    w_nxt = IDLE;
            endcase
            if (w_retry) begin
                w_nxt = (r_retry_cnt == MAX_RETRY) ? FAULT_ST : QPLL_WAIT;
            end
        end
    end

    // A retry from QPLL_WAIT re-enters the same state, so it must clear the timer too.
    assign w_tmr_clr = (w_nxt != r_state) || w_retry;
    assign w_flt_clr = (r_state != LINK_OK) || !w_bad;

    init_tmo_cntr #(.W(TMO_W)) u_state_tmr (
        .clk        (CLK),
        .rst        (RST),
        .i_clr      (w_tmr_clr),
        .i_load     (1'b0),
        .i_load_val ({TMO_W{1'b0}}),
        .i_en       (1'b1),
        .i_tc_val   (w_tmr_lim),
        .o_tc       (w_tmr_tc)
    );

    init_tmo_cntr #(.W(4)) u_loss_filt (
        .clk        (CLK),
        .rst        (RST),
        .i_clr      (w_flt_clr),
        .i_load     (1'b0),
        .i_load_val (4'd0),
        .i_en       (1'b1),
        .i_tc_val   (LOSS_FILT - 4'd1),
        .o_tc       (w_flt_tc)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= IDLE;
            r_gt_rst    <= 1'b1;
            r_gbt_rst   <= 1'b1;
            r_link_up   <= 1'b0;
            r_fault     <= 1'b0;
            r_retry_cnt <= 4'd0;
        end else begin
            r_state   <= w_nxt;
            r_gt_rst  <= gt_rst_on(w_nxt);
            r_gbt_rst <= gbt_rst_on(w_nxt);
            r_link_up <= (w_nxt == LINK_OK);
            r_fault   <= (w_nxt == FAULT_ST);
            if (!RUN) begin
                r_retry_cnt <= 4'd0;
            end else if (w_retry && (r_retry_cnt != MAX_RETRY) && (r_retry_cnt != 4'hF)) begin
                r_retry_cnt <= r_retry_cnt + 4'd1;
            end
        end
    end

`ifdef GBT_LINK_STATS_EN
    logic [7:0] r_loss_cnt;

    // Survives RUN=0 on purpose: only a hard reset clears the history.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_loss_cnt <= 8'h00;
        end else if (RUN && w_loss && (r_loss_cnt != 8'hFF)) begin
            r_loss_cnt <= r_loss_cnt + 8'h01;
        end
    end

    assign LOSS_CNT = r_loss_cnt;
`else
    assign LOSS_CNT = 8'h00;
`endif

    assign STATE     = r_state;
    assign GT_RST    = r_gt_rst;
    assign GBT_RST   = r_gbt_rst;
    assign LINK_UP   = r_link_up;
    assign FAULT     = r_fault;
    assign RETRY_CNT = r_retry_cnt;

endmodule

`default_nettype wire
